// File: rtl/spi_master_multi.sv
// SPI master with configurable word width, SCLK divider, CPOL/CPHA mode
// and one-hot active-low slave selects. Full-duplex, MSB-first.
module spi_master_multi #(
  parameter  int DATA_W = 16,
  parameter  int DIV    = 16,
  parameter  int NUM_SS = 4,
  localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt,
  input  logic [DATA_W-1:0] cmd,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              MISO,
  output logic              SCLK,
  output logic              MOSI,
  output logic [NUM_SS-1:0] SS_n,
  output logic [DATA_W-1:0] data,
  output logic              done,
  output logic              busy
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int KW = $clog2(2 * DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(2 * DATA_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [KW-1:0]     k;
  logic [DATA_W-1:0] tx;
  logic [DATA_W-1:0] rx;
  logic              cpol_l;
  logic              cpha_l;
  logic              miso_s1;
  logic              miso_s2;

  logic              half_end;
  logic              start_half;
  logic [KW-1:0]     k_new;
  logic              leading;
  logic              do_sample;
  logic              do_shift;

  // Decode a slave index into active-low selects; out-of-range selects nobody.
  function automatic logic [NUM_SS-1:0] decode_ss(input logic [SS_W-1:0] sel);
    logic [NUM_SS-1:0] d;
    for (int i = 0; i < NUM_SS; i++) begin
      d[i] = (sel != SS_W'(i));
    end
    return d;
  endfunction

  // Two-flop synchroniser for the asynchronous MISO pad.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
    end else begin
      miso_s1 <= MISO;
      miso_s2 <= miso_s1;
    end
  end

  // Half-period bookkeeping: which half starts next and what happens on its edge.
  always_comb begin
    half_end   = (cnt == CNT_LAST);
    start_half = half_end && ((state == SETUP) || ((state == XFER) && (k != K_LAST)));
    k_new      = (state == SETUP) ? '0 : k + KW'(1);
    leading    = ~k_new[0];
    do_sample  = start_half && (leading ^ cpha_l);
    do_shift   = start_half && !(leading ^ cpha_l) && (k_new != '0) && (k_new != K_LAST);
  end

  // Transfer state machine with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      k      <= '0;
      tx     <= '0;
      rx     <= '0;
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
      SCLK   <= 1'b0;
      MOSI   <= 1'b0;
      SS_n   <= '1;
      data   <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          SS_n <= '1;
          if (wrt) begin
            state  <= SETUP;
            cnt    <= '0;
            k      <= '0;
            tx     <= cmd;
            cpol_l <= cpol;
            cpha_l <= cpha;
            SS_n   <= decode_ss(ss_sel);
            SCLK   <= cpol;
            MOSI   <= cmd[DATA_W-1];
            busy   <= 1'b1;
          end else begin
            state <= IDLE;
            SCLK  <= cpol_l;
          end
        end
        SETUP, XFER: begin
          cnt <= half_end ? '0 : cnt + CW'(1);
          if (start_half) begin
            state <= XFER;
            k     <= k_new;
            SCLK  <= cpol_l ^ leading;
          end else if (half_end) begin
            state <= HOLD;
            SCLK  <= cpol_l;
          end
          if (do_sample) begin
            rx <= {rx[DATA_W-2:0], miso_s2};
          end
          if (do_shift) begin
            tx   <= {tx[DATA_W-2:0], 1'b0};
            MOSI <= tx[DATA_W-2];
          end
        end
        HOLD: begin
          if (half_end) begin
            state <= DONE;
            cnt   <= '0;
            SS_n  <= '1;
            done  <= 1'b1;
            data  <= rx;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi with a behavioural SPI slave.
module tb_spi_master_multi;

  localparam int W  = 16;
  localparam int DV = 4;
  localparam int NS = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wrt;
  logic [W-1:0]  cmd;
  logic [SW-1:0] ss_sel;
  logic          cpol;
  logic          cpha;
  logic          MISO;
  logic          SCLK;
  logic          MOSI;
  logic [NS-1:0] SS_n;
  logic [W-1:0]  data;
  logic          done;
  logic          busy;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int cyc    = 0;
  int t0     = 0;
  int d1_cyc = 0;

  logic [W-1:0]  slave_word = '0;
  logic [W-1:0]  slave_tx   = '0;
  logic          cur_cpol   = 1'b0;
  logic          cur_cpha   = 1'b0;
  int            lead_cnt   = 0;
  logic          sclk_prev  = 1'b0;
  logic          mosi_prev  = 1'b0;
  logic          busy_prev  = 1'b0;
  logic [NS-1:0] ss_prev    = '1;
  logic [W-1:0]  mosi_cap   = '0;
  logic [NS-1:0] ss_seen    = '0;
  int            mosi_bad   = 0;
  int            done_cnt   = 0;
  int            done_cyc   = 0;
  logic [W-1:0]  done_data  = '0;
  logic [W-1:0]  frame_mosi = '0;
  logic [NS-1:0] frame_ss   = '0;
  logic [NS-1:0] pre_done_ss = '0;

  spi_master_multi #(.DATA_W(W), .DIV(DV), .NUM_SS(NS)) dut (
    .clk(clk), .rst(rst), .wrt(wrt), .cmd(cmd), .ss_sel(ss_sel),
    .cpol(cpol), .cpha(cpha), .MISO(MISO), .SCLK(SCLK), .MOSI(MOSI),
    .SS_n(SS_n), .data(data), .done(done), .busy(busy)
  );

  assign MISO = slave_tx[W-1];

  always #5 clk = ~clk;

  // Cycle counter used for latency checks.
  always @(posedge clk) cyc++;

  // Slave model and frame monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    logic active, chg, lead, trail;
    active = busy && busy_prev;
    chg    = (SCLK != sclk_prev);
    lead   = active && chg && (SCLK != cur_cpol);
    trail  = active && chg && (SCLK == cur_cpol);
    if (rst) begin
      mosi_cap = '0;
      ss_seen  = '0;
    end
    if (active && chg && SCLK) mosi_cap = {mosi_cap[W-2:0], MOSI};
    if (active && (MOSI != mosi_prev) && !(chg && !SCLK)) mosi_bad++;
    if (busy) ss_seen = ss_seen | ~SS_n;
    if (busy) begin
      if (!cur_cpha && trail) slave_tx = {slave_tx[W-2:0], 1'b0};
      if (cur_cpha && lead) begin
        if (lead_cnt != 0) slave_tx = {slave_tx[W-2:0], 1'b0};
        lead_cnt++;
      end
    end else begin
      slave_tx = slave_word;
      lead_cnt = 0;
    end
    if (done) begin
      done_cnt++;
      done_cyc    = cyc;
      done_data   = data;
      frame_mosi  = mosi_cap;
      frame_ss    = ss_seen;
      pre_done_ss = ss_prev;
      mosi_cap    = '0;
      ss_seen     = '0;
    end
    sclk_prev = SCLK;
    mosi_prev = MOSI;
    busy_prev = busy;
    ss_prev   = SS_n;
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] c, input logic [SW-1:0] s,
                               input logic p, input logic h, input logic [W-1:0] sw);
    slave_word = sw;
    cur_cpol   = p;
    cur_cpha   = h;
    waitCycles(1);
    cmd    = c;
    ss_sel = s;
    cpol   = p;
    cpha   = h;
    wrt    = 1'b1;
    t0     = cyc;
    waitCycles(1);
    wrt    = 1'b0;
  endtask

  task automatic waitDone(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 400) begin
      waitCycles(1);
      n++;
    end
    checkOutput(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  // Directed test sequence.
  initial begin
    rst = 1'b1; wrt = 1'b0; cmd = '0; ss_sel = '0; cpol = 1'b0; cpha = 1'b0;
    waitCycles(3);
    checkOutput("rst_ss_n", 32'(SS_n), 32'h7);
    checkOutput("rst_sclk", 32'(SCLK), 32'h0);
    checkOutput("rst_mosi", 32'(MOSI), 32'h0);
    checkOutput("rst_data", 32'(data), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    waitCycles(2);

    // Mode 0 to slave 2
    applyStimulus(16'hA55A, 2'd2, 1'b0, 1'b0, 16'h3C96);
    checkOutput("m0_setup_busy", 32'(busy), 32'h1);
    waitDone(1, "m0_done_timeout");
    checkOutput("m0_latency", 32'(done_cyc - t0), 32'd137);
    checkOutput("m0_data", 32'(data), 32'h3C96);
    checkOutput("m0_mosi", 32'(frame_mosi), 32'hA55A);
    checkOutput("m0_ss_seen", 32'(frame_ss), 32'h4);
    checkOutput("m0_hold_ss", 32'(pre_done_ss), 32'h3);
    checkOutput("m0_done_ss", 32'(SS_n), 32'h7);
    waitCycles(1);
    checkOutput("m0_done_pulse", 32'(done), 32'h0);
    checkOutput("m0_idle_sclk", 32'(SCLK), 32'h0);

    // Mode 3
    applyStimulus(16'h8001, 2'd2, 1'b1, 1'b1, 16'hFFFE);
    checkOutput("m3_setup_sclk", 32'(SCLK), 32'h1);
    waitDone(2, "m3_done_timeout");
    checkOutput("m3_latency", 32'(done_cyc - t0), 32'd137);
    checkOutput("m3_data", 32'(data), 32'hFFFE);
    checkOutput("m3_mosi", 32'(frame_mosi), 32'h8001);
    waitCycles(2);
    checkOutput("m3_idle_sclk", 32'(SCLK), 32'h1);
    checkOutput("mosi_edges", 32'(mosi_bad), 32'h0);

    // Back-to-back frames
    applyStimulus(16'hABCD, 2'd2, 1'b0, 1'b0, 16'h1357);
    slave_word = 16'h2468;
    waitDone(3, "b2b1_done_timeout");
    d1_cyc = done_cyc;
    checkOutput("b2b1_data", 32'(data), 32'h1357);
    checkOutput("b2b1_mosi", 32'(frame_mosi), 32'hABCD);
    checkOutput("b2b_gap_ss", 32'(SS_n), 32'h7);
    cmd = 16'h1234;
    wrt = 1'b1;
    waitCycles(1);
    wrt = 1'b0;
    checkOutput("b2b_setup_ss", 32'(SS_n), 32'h3);
    waitDone(4, "b2b2_done_timeout");
    checkOutput("b2b_spacing", 32'(done_cyc - d1_cyc), 32'd137);
    checkOutput("b2b2_data", 32'(data), 32'h2468);
    checkOutput("b2b2_mosi", 32'(frame_mosi), 32'h1234);

    // Ignored wrt in the middle of a frame
    applyStimulus(16'hC3A5, 2'd2, 1'b0, 1'b0, 16'h0F0F);
    waitCycles(40);
    cmd = 16'hFFFF;
    ss_sel = 2'd0;
    wrt = 1'b1;
    waitCycles(1);
    wrt = 1'b0;
    waitDone(5, "mid_done_timeout");
    checkOutput("mid_data", 32'(data), 32'h0F0F);
    checkOutput("mid_mosi", 32'(frame_mosi), 32'hC3A5);
    checkOutput("mid_ss_seen", 32'(frame_ss), 32'h4);
    waitCycles(150);
    checkOutput("mid_one_done", 32'(done_cnt), 32'd5);

    // Reset during half-period 9 of a mode-3 frame
    applyStimulus(16'h5A5A, 2'd2, 1'b1, 1'b1, 16'h1111);
    waitCycles(41);
    checkOutput("rstx_pre_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("rstx_ss_n", 32'(SS_n), 32'h7);
    checkOutput("rstx_sclk", 32'(SCLK), 32'h0);
    checkOutput("rstx_busy", 32'(busy), 32'h0);
    checkOutput("rstx_data", 32'(data), 32'h0);
    #1;
    rst = 1'b0;
    waitCycles(200);
    checkOutput("rstx_no_done", 32'(done_cnt), 32'd5);
    applyStimulus(16'h6C39, 2'd2, 1'b0, 1'b0, 16'h9AC3);
    waitDone(6, "post_done_timeout");
    checkOutput("post_data", 32'(data), 32'h9AC3);
    checkOutput("post_mosi", 32'(frame_mosi), 32'h6C39);

    // Out-of-range slave index
    applyStimulus(16'h7E81, 2'd3, 1'b0, 1'b0, 16'h5A0F);
    waitDone(7, "oor_done_timeout");
    checkOutput("oor_latency", 32'(done_cyc - t0), 32'd137);
    checkOutput("oor_ss_seen", 32'(frame_ss), 32'h0);
    checkOutput("oor_data", 32'(data), 32'h5A0F);
    checkOutput("oor_mosi", 32'(frame_mosi), 32'h7E81);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard stop in case a wait never resolves.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
